// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and the long-latency queue entry type
//
// Purpose: common definitions for the writeback arbiter and its FIFO.
//   REG_ADDR_W : register-file address width
//   DATA_W     : register data width
//   wb_entry_t : one queued long-latency result {rw, data}
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order queue of long-latency writeback entries
//
// Purpose: small FIFO of wb_entry_t; push and pop may happen on the same edge.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties the queue)
//   push, push_data  : enqueue request and entry (ignored when full)
//   pop              : dequeue request (ignored when empty)
//   head             : entry at the front of the queue
//   full, empty      : registered occupancy flags
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  // One extra bit so that DEPTH entries and zero entries are distinguishable.
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter (pipeline vs long-latency)
//
// Purpose: drives the single register-file write port. Pipeline results always
// win; queued long-latency results drain when the pipeline is not writing.
// Optional macro WB_SCOREBOARD_EN enables the Busy scoreboard; otherwise Busy = 0.
// Ports:
//   Clk, Reset                  : clock, synchronous active-high reset
//   PipeWr, PipeRw, PipeData    : pipeline writeback request (never stalled)
//   LlValid, LlRw, LlData       : long-latency result, handshaked with LlReady
//   LlReady                     : queue can accept this cycle
//   IssueVal, IssueRw           : long-latency op issued (sets Busy)
//   busW, Rw, RegWr             : registered register-file write port
//   Busy                        : per-register pending-long-latency flags
module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           PipeWr,
  input  logic [wb_pkg::REG_ADDR_W-1:0]  PipeRw,
  input  logic [DATA_W-1:0]              PipeData,
  input  logic                           LlValid,
  input  logic [wb_pkg::REG_ADDR_W-1:0]  LlRw,
  input  logic [DATA_W-1:0]              LlData,
  output logic                           LlReady,
  input  logic                           IssueVal,
  input  logic [wb_pkg::REG_ADDR_W-1:0]  IssueRw,
  output logic [DATA_W-1:0]              busW,
  output logic [wb_pkg::REG_ADDR_W-1:0]  Rw,
  output logic                           RegWr,
  output logic [31:0]                    Busy
);

  import wb_pkg::*;

  wb_entry_t ll_entry;
  wb_entry_t head;
  logic      full;
  logic      empty;
  logic      pipe_go;
  logic      pop;
  logic      push;
  // Marks that the write currently on the port came from the queue, so the
  // scoreboard knows which writes retire a pending register.
  logic      ll_wr;

  assign ll_entry.rw   = LlRw;
  assign ll_entry.data = LlData;

  assign pipe_go = PipeWr && (PipeRw != '0);
  assign pop     = !pipe_go && !empty;
  // Occupancy is registered, so readiness never depends on a same-cycle pop.
  assign LlReady = !full && !Reset;
  assign push    = LlValid && LlReady;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .reset    (Reset),
    .push     (push),
    .push_data(ll_entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Rw/busW hold their last values whenever nothing is written, including
  // dropped register-0 requests.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWr <= 1'b0;
      ll_wr <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
    end else begin
      RegWr <= 1'b0;
      ll_wr <= 1'b0;
      if (pipe_go) begin
        RegWr <= 1'b1;
        Rw    <= PipeRw;
        busW  <= PipeData;
      end else if (pop && (head.rw != '0)) begin
        RegWr <= 1'b1;
        ll_wr <= 1'b1;
        Rw    <= head.rw;
        busW  <= head.data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_next;

  // Clear first, then set, so a same-edge issue to the retiring register wins.
  always_comb begin
    busy_next = busy_q;
    if (RegWr && ll_wr) busy_next[Rw] = 1'b0;
    if (IssueVal && (IssueRw != '0)) busy_next[IssueRw] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_next;
  end

  assign Busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{IssueVal, IssueRw, ll_wr};
  assign Busy = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
module tb_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PipeWr;
  logic [4:0]  PipeRw;
  logic [31:0] PipeData;
  logic        LlValid;
  logic [4:0]  LlRw;
  logic [31:0] LlData;
  logic        LlReady;
  logic        IssueVal;
  logic [4:0]  IssueRw;
  logic [31:0] busW;
  logic [4:0]  Rw;
  logic        RegWr;
  logic [31:0] Busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  wb_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .PipeWr  (PipeWr),
    .PipeRw  (PipeRw),
    .PipeData(PipeData),
    .LlValid (LlValid),
    .LlRw    (LlRw),
    .LlData  (LlData),
    .LlReady (LlReady),
    .IssueVal(IssueVal),
    .IssueRw (IssueRw),
    .busW    (busW),
    .Rw      (Rw),
    .RegWr   (RegWr),
    .Busy    (Busy)
  );

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  prw;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrw;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  irw;
    logic        e_wr;
    logic [4:0]  e_rw;
    logic [31:0] e_bw;
    logic        e_rdy;
    logic [31:0] e_busy;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic pw, logic [4:0] prw, logic [31:0] pd,
                              logic lv, logic [4:0] lrw, logic [31:0] ld,
                              logic iv, logic [4:0] irw,
                              logic e_wr, logic [4:0] e_rw, logic [31:0] e_bw,
                              logic e_rdy, logic [31:0] e_busy, string name);
    vec_t v;
    v.rst = rst; v.pw = pw; v.prw = prw; v.pd = pd;
    v.lv = lv; v.lrw = lrw; v.ld = ld; v.iv = iv; v.irw = irw;
    v.e_wr = e_wr; v.e_rw = e_rw; v.e_bw = e_bw; v.e_rdy = e_rdy;
    v.e_busy = SB ? e_busy : 32'h0;
    v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", name, field, act, exp);
    end
  endtask

  task automatic drive_idle();
    Reset = 1'b0; PipeWr = 1'b0; PipeRw = '0; PipeData = '0;
    LlValid = 1'b0; LlRw = '0; LlData = '0; IssueVal = 1'b0; IssueRw = '0;
  endtask

  initial begin
    int waited;
    bit seen;
    drive_idle();
    //          rst pw prw pd        lv lrw ld          iv irw  wr rw  bw          rdy busy
    vecs.push_back(mk(1, 0, 0, 0,       0, 0,  0,          0, 0,  0, 0,  0,          0, 0,      "reset_held"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 0,  0,          1, 0,      "post_reset"));
    vecs.push_back(mk(0, 1, 8, 'h1234,  0, 0,  0,          0, 0,  1, 8,  'h1234,     1, 0,      "pipe_wr"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 8,  'h1234,     1, 0,      "pipe_done"));
    vecs.push_back(mk(0, 1, 0, 'h5555,  0, 0,  0,          0, 0,  0, 8,  'h1234,     1, 0,      "pipe_rw0"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          1, 9,  0, 8,  'h1234,     1, 'h200,  "issue9"));
    vecs.push_back(mk(0, 0, 0, 0,       1, 9,  'hDEADBEEF, 0, 0,  0, 8,  'h1234,     1, 'h200,  "ll_accept"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  1, 9,  'hDEADBEEF, 1, 'h200,  "ll_write"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 9,  'hDEADBEEF, 1, 0,      "busy9_clear"));
    vecs.push_back(mk(0, 1, 1, 'h100,   1, 10, 'hA,        0, 0,  1, 1,  'h100,      1, 0,      "cont1"));
    vecs.push_back(mk(0, 1, 2, 'h101,   1, 11, 'hB,        0, 0,  1, 2,  'h101,      0, 0,      "cont2_full"));
    vecs.push_back(mk(0, 1, 3, 'h102,   1, 12, 'hC,        0, 0,  1, 3,  'h102,      0, 0,      "cont3"));
    vecs.push_back(mk(0, 1, 4, 'h103,   1, 12, 'hC,        0, 0,  1, 4,  'h103,      0, 0,      "cont4"));
    vecs.push_back(mk(0, 1, 5, 'h104,   1, 12, 'hC,        0, 0,  1, 5,  'h104,      0, 0,      "cont5"));
    vecs.push_back(mk(0, 0, 0, 0,       1, 12, 'hC,        0, 0,  1, 10, 'hA,        1, 0,      "pop_a"));
    vecs.push_back(mk(0, 0, 0, 0,       1, 12, 'hC,        0, 0,  1, 11, 'hB,        1, 0,      "pop_b_push_c"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  1, 12, 'hC,        1, 0,      "pop_c"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 12, 'hC,        1, 0,      "drained"));
    vecs.push_back(mk(0, 1, 6, 'h200,   1, 0,  'h77,       0, 0,  1, 6,  'h200,      1, 0,      "q_rw0"));
    vecs.push_back(mk(0, 1, 7, 'h201,   1, 13, 'h88,       0, 0,  1, 7,  'h201,      0, 0,      "q_rw13"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 7,  'h201,      1, 0,      "pop_rw0"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  1, 13, 'h88,       1, 0,      "after_rw0"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 13, 'h88,       1, 0,      "idle_a"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          1, 5,  0, 13, 'h88,       1, 'h20,   "issue5"));
    vecs.push_back(mk(0, 1, 0, 'h999,   1, 5,  'h55,       0, 0,  0, 13, 'h88,       1, 'h20,   "drop_rw0_push"));
    vecs.push_back(mk(0, 1, 0, 'h999,   0, 0,  0,          0, 0,  1, 5,  'h55,       1, 'h20,   "pop_under_rw0"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          1, 5,  0, 5,  'h55,       1, 'h20,   "race_set_wins"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 5,  'h55,       1, 'h20,   "race_hold"));
    vecs.push_back(mk(0, 0, 0, 0,       1, 5,  'h56,       1, 9,  0, 5,  'h55,       1, 'h220,  "sb_push5"));
    vecs.push_back(mk(0, 0, 0, 0,       1, 20, 'h20,       1, 10, 1, 5,  'h56,       1, 'h620,  "sb_pop5"));
    vecs.push_back(mk(0, 1, 3, 'h300,   1, 21, 'h21,       0, 0,  1, 3,  'h300,      0, 'h600,  "two_queued"));
    vecs.push_back(mk(1, 0, 0, 0,       0, 0,  0,          0, 0,  0, 0,  0,          0, 0,      "reset_mid"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 0,  0,          1, 0,      "no_stale1"));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0,  0,          0, 0,  0, 0,  0,          1, 0,      "no_stale2"));

    foreach (vecs[i]) begin
      Reset = vecs[i].rst; PipeWr = vecs[i].pw; PipeRw = vecs[i].prw; PipeData = vecs[i].pd;
      LlValid = vecs[i].lv; LlRw = vecs[i].lrw; LlData = vecs[i].ld;
      IssueVal = vecs[i].iv; IssueRw = vecs[i].irw;
      @(posedge Clk); #1;
      check(vecs[i].name, "RegWr",   32'(RegWr),   32'(vecs[i].e_wr));
      check(vecs[i].name, "Rw",      32'(Rw),      32'(vecs[i].e_rw));
      check(vecs[i].name, "busW",    busW,         vecs[i].e_bw);
      check(vecs[i].name, "LlReady", 32'(LlReady), 32'(vecs[i].e_rdy));
      check(vecs[i].name, "Busy",    Busy,         vecs[i].e_busy);
    end

    // LlReady rises as soon as Reset drops, before any further edge.
    drive_idle();
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("rdy_in_reset", "LlReady", 32'(LlReady), 32'h0);
    Reset = 1'b0;
    #1;
    check("rdy_after_reset", "LlReady", 32'(LlReady), 32'h1);

    // Single long-latency result: write appears exactly one edge after acceptance.
    LlValid = 1'b1; LlRw = 5'd17; LlData = 32'h1234_5678;
    @(posedge Clk); #1;
    drive_idle();
    check("ll_lat_accept", "RegWr", 32'(RegWr), 32'h0);
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 4) begin
      @(posedge Clk); #1;
      waited++;
      if (RegWr) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL ll_lat/timeout got=no_write exp=write_within_4");
    end else begin
      check("ll_lat", "cycles", 32'(waited), 32'd1);
      check("ll_lat", "Rw",     32'(Rw),     32'd17);
      check("ll_lat", "busW",   busW,        32'h1234_5678);
    end
    @(posedge Clk); #1;
    check("ll_lat_done", "RegWr", 32'(RegWr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
